// File: rtl/arm_defs.sv
// Shared encodings for the ARM core: instruction modes, DP opcodes, EXE commands,
// condition codes and the decoded control bundle.
package arm_defs;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       wb_en;
    logic       b;
    logic       s;
  } ctrl_t;

endpackage

// File: rtl/condition_check.sv
// Evaluates an ARM condition field against {N,Z,C,V}; the 1111 encoding never passes.
module condition_check
  import arm_defs::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = status;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Decodes mode/opcode/S into the EXE control bundle; unknown encodings decode to all-zero.
module control_unit
  import arm_defs::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_bit,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (mode)
      MODE_DP: begin
        ctrl.wb_en = 1'b1;
        ctrl.s     = s_bit;
        case (opcode)
          OP_MOV: ctrl.exe_cmd = EXE_MOV;
          OP_MVN: ctrl.exe_cmd = EXE_MVN;
          OP_ADD: ctrl.exe_cmd = EXE_ADD;
          OP_ADC: ctrl.exe_cmd = EXE_ADC;
          OP_SUB: ctrl.exe_cmd = EXE_SUB;
          OP_SBC: ctrl.exe_cmd = EXE_SBC;
          OP_AND: ctrl.exe_cmd = EXE_AND;
          OP_ORR: ctrl.exe_cmd = EXE_ORR;
          OP_EOR: ctrl.exe_cmd = EXE_EOR;
          // Compare/test only update flags, so nothing is written back.
          OP_CMP: begin
            ctrl.exe_cmd = EXE_SUB;
            ctrl.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl.exe_cmd = EXE_AND;
            ctrl.wb_en   = 1'b0;
          end
          default: ctrl = '0;
        endcase
      end
      MODE_MEM: begin
        ctrl.exe_cmd = EXE_ADD;
        if (s_bit) begin
          ctrl.mem_r_en = 1'b1;
          ctrl.wb_en    = 1'b1;
        end else begin
          ctrl.mem_w_en = 1'b1;
        end
      end
      MODE_BR: ctrl.b = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// R0..R(REG_COUNT-1) with combinational reads; index REG_COUNT reads the PC and a
// same-cycle write to the read register is forwarded.
module register_file #(
  parameter int REG_COUNT = 15,
  parameter int WORD      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  logic [3:0]      wb_dest,
  input  logic [WORD-1:0] wb_value,
  input  logic [WORD-1:0] pc,
  input  logic [3:0]      rd_idx1,
  input  logic [3:0]      rd_idx2,
  output logic [WORD-1:0] rd_data1,
  output logic [WORD-1:0] rd_data2
);

  localparam logic [3:0] PC_IDX = 4'(REG_COUNT);

  logic [WORD-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_en && wb_dest != PC_IDX) begin
      regs[wb_dest] <= wb_value;
    end
  end

  function automatic logic [WORD-1:0] read_port(input logic [3:0] idx);
    if (idx == PC_IDX)
      return pc;
    else if (wb_en && wb_dest == idx)
      return wb_value;
    else
      return regs[idx];
  endfunction

  always_comb begin
    rd_data1 = read_port(rd_idx1);
    rd_data2 = read_port(rd_idx2);
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage and ID/EX register: decodes, condition-checks and reads operands,
// then registers everything for EXE. Source indices go combinationally to hazard logic.
module id_stage
  import arm_defs::*;
#(
  parameter int REG_COUNT = 15,
  parameter int WORD      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] pc_in,
  input  logic [31:0]     instruction,
  input  logic [3:0]      status,
  input  logic            hazard,
  input  logic            flush,
  input  logic            wb_en_in,
  input  logic [3:0]      wb_dest,
  input  logic [WORD-1:0] wb_value,
  output logic [3:0]      src1,
  output logic [3:0]      src2,
  output logic            two_src,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] val_rn,
  output logic [WORD-1:0] val_rm,
  output logic [3:0]      exe_cmd,
  output logic            mem_r_en,
  output logic            mem_w_en,
  output logic            wb_en,
  output logic            b,
  output logic            s,
  output logic            imm,
  output logic [11:0]     shift_operand,
  output logic [23:0]     signed_imm_24,
  output logic [3:0]      dest
);

  ctrl_t           ctrl;
  ctrl_t           ctrl_gated;
  logic            cond_pass;
  logic [WORD-1:0] rn_data;
  logic [WORD-1:0] rm_data;

  control_unit u_ctrl (
    .mode   (instruction[27:26]),
    .opcode (instruction[24:21]),
    .s_bit  (instruction[20]),
    .ctrl   (ctrl)
  );

  condition_check u_cond (
    .cond   (instruction[31:28]),
    .status (status),
    .pass   (cond_pass)
  );

  // STR reads Rd as the store data, so it takes the second read port.
  assign src1    = instruction[19:16];
  assign src2    = ctrl.mem_w_en ? instruction[15:12] : instruction[3:0];
  assign two_src = ~instruction[25] | ctrl.mem_w_en;

  register_file #(
    .REG_COUNT (REG_COUNT),
    .WORD      (WORD)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en_in),
    .wb_dest  (wb_dest),
    .wb_value (wb_value),
    .pc       (pc_in),
    .rd_idx1  (src1),
    .rd_idx2  (src2),
    .rd_data1 (rn_data),
    .rd_data2 (rm_data)
  );

  assign ctrl_gated = (cond_pass && !hazard) ? ctrl : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      pc            <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      exe_cmd       <= '0;
      mem_r_en      <= 1'b0;
      mem_w_en      <= 1'b0;
      wb_en         <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      imm           <= 1'b0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
    end else begin
      pc            <= pc_in;
      val_rn        <= rn_data;
      val_rm        <= rm_data;
      exe_cmd       <= ctrl_gated.exe_cmd;
      mem_r_en      <= ctrl_gated.mem_r_en;
      mem_w_en      <= ctrl_gated.mem_w_en;
      wb_en         <= ctrl_gated.wb_en;
      b             <= ctrl_gated.b;
      s             <= ctrl_gated.s;
      imm           <= instruction[25];
      shift_operand <= instruction[11:0];
      signed_imm_24 <= instruction[23:0];
      dest          <= instruction[15:12];
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic        hazard;
  logic        flush;
  logic        wb_en_in;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [3:0]  src1, src2;
  logic        two_src;
  logic [31:0] pc, val_rn, val_rm;
  logic [3:0]  exe_cmd;
  logic        mem_r_en, mem_w_en, wb_en, b, s, imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;

  int n_vec = 0;
  int n_err = 0;

  id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .instruction   (instruction),
    .status        (status),
    .hazard        (hazard),
    .flush         (flush),
    .wb_en_in      (wb_en_in),
    .wb_dest       (wb_dest),
    .wb_value      (wb_value),
    .src1          (src1),
    .src2          (src2),
    .two_src       (two_src),
    .pc            (pc),
    .val_rn        (val_rn),
    .val_rm        (val_rm),
    .exe_cmd       (exe_cmd),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .wb_en         (wb_en),
    .b             (b),
    .s             (s),
    .imm           (imm),
    .shift_operand (shift_operand),
    .signed_imm_24 (signed_imm_24),
    .dest          (dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Control fields packed as {exe_cmd, mem_r_en, mem_w_en, wb_en, b, s}.
  task automatic check_ctrl(input string tag, input logic [8:0] exp);
    check(tag, {23'd0, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s}, {23'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    pc_in       = 32'h100;
    instruction = 32'hE000_0000;
    status      = 4'b0000;
    hazard      = 1'b0;
    flush       = 1'b0;
    wb_en_in    = 1'b0;
    wb_dest     = 4'd0;
    wb_value    = 32'd0;

    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_ctrl", {23'd0, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s}, 32'h0);
    check("rst_dest", {28'd0, dest}, 32'h0);

    // Release reset away from the edge: outputs must stay 0 until the next edge.
    rst = 1'b1;
    #1;
    check("rel_exe_before_edge", {28'd0, exe_cmd}, 32'h0);
    step();
    check_ctrl("and_ctrl", 9'b0110_0_0_1_0_0);
    check("and_pc", pc, 32'h100);

    // ADD R1,R2,R3 with a same-cycle writeback of R2.
    instruction = 32'hE082_1003;
    wb_en_in = 1'b1; wb_dest = 4'd2; wb_value = 32'h55;
    #1;
    check("add_src1", {28'd0, src1}, 32'd2);
    check("add_src2", {28'd0, src2}, 32'd3);
    check("add_two_src", {31'd0, two_src}, 32'd1);
    step();
    check("add_bypass_rn", val_rn, 32'h55);
    check_ctrl("add_ctrl", 9'b0010_0_0_1_0_0);
    check("add_dest", {28'd0, dest}, 32'd1);
    check("add_shift", {20'd0, shift_operand}, 32'h003);
    wb_en_in = 1'b0;
    step();
    check("add_stored_rn", val_rn, 32'h55);
    check("add_rm", val_rm, 32'h0);

    // ADDNE: Z=1 fails, Z=0 passes; data fields register either way.
    instruction = 32'h1082_1003;
    status = 4'b0100;
    step();
    check_ctrl("addne_fail_ctrl", 9'b0);
    check("addne_fail_dest", {28'd0, dest}, 32'd1);
    status = 4'b0000;
    step();
    check_ctrl("addne_pass_ctrl", 9'b0010_0_0_1_0_0);

    // ADDLT: N!=V passes, N==V fails.
    instruction = 32'hB082_1003;
    status = 4'b1000;
    step();
    check_ctrl("addlt_pass", 9'b0010_0_0_1_0_0);
    status = 4'b1001;
    step();
    check_ctrl("addlt_fail", 9'b0);
    status = 4'b0000;

    // Condition 1111 never passes.
    instruction = 32'hF082_1003;
    step();
    check_ctrl("cond_nv", 9'b0);

    // CMPS R1,R2: flags only.
    instruction = 32'hE151_0002;
    step();
    check_ctrl("cmp_ctrl", 9'b0100_0_0_0_0_1);

    // Mode 11 is a NOP.
    instruction = 32'hEC00_0000;
    step();
    check_ctrl("mode11_nop", 9'b0);

    // STR R0,[R1] then LDR R0,[R1].
    instruction = 32'hE581_0000;
    #1;
    check("str_src2", {28'd0, src2}, 32'd0);
    check("str_two_src", {31'd0, two_src}, 32'd1);
    step();
    check_ctrl("str_ctrl", 9'b0010_0_1_0_0_0);
    instruction = 32'hE591_0000;
    step();
    check_ctrl("ldr_ctrl", 9'b0010_1_0_1_0_0);

    // MOV R1,R2 under hazard, then hazard+flush, then clean.
    instruction = 32'hE1A0_1002;
    hazard = 1'b1;
    step();
    check_ctrl("mov_hazard_ctrl", 9'b0);
    check("mov_hazard_shift", {20'd0, shift_operand}, 32'h002);
    flush = 1'b1;
    step();
    check_ctrl("flush_ctrl", 9'b0);
    check("flush_pc", pc, 32'h0);
    check("flush_dest", {28'd0, dest}, 32'h0);
    check("flush_shift", {20'd0, shift_operand}, 32'h0);
    hazard = 1'b0; flush = 1'b0;
    step();
    check_ctrl("mov_ctrl", 9'b0001_0_0_1_0_0);

    // B -2.
    instruction = 32'hEAFF_FFFE;
    step();
    check_ctrl("b_ctrl", 9'b0000_0_0_0_1_0);
    check("b_imm24", {8'd0, signed_imm_24}, 32'h00FF_FFFE);
    check("b_imm", {31'd0, imm}, 32'd1);

    // A write to R15 is ignored; Rn=15 reads pc_in.
    pc_in = 32'h200;
    instruction = 32'hE08F_1003;
    wb_en_in = 1'b1; wb_dest = 4'd15; wb_value = 32'hDEAD_BEEF;
    step();
    check("r15_bypass_rn", val_rn, 32'h200);
    wb_en_in = 1'b0;
    step();
    check("r15_rn", val_rn, 32'h200);

    // Write R4, confirm, then pulse reset mid-cycle and confirm R4 cleared.
    instruction = 32'hE084_1003;
    wb_en_in = 1'b1; wb_dest = 4'd4; wb_value = 32'h77;
    step();
    wb_en_in = 1'b0;
    step();
    check("r4_written", val_rn, 32'h77);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_rn", val_rn, 32'h0);
    check("async_rst_pc", pc, 32'h0);
    #1;
    rst = 1'b1;
    step();
    check("r4_after_rst", val_rn, 32'h0);
    check_ctrl("add_after_rst", 9'b0010_0_0_1_0_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage plus ID/EX pipeline register for the 5-stage ARM core. It consumes `pc`/`instruction` from the IF/ID register and decodes the instruction. It evaluates the condition field against the status flags and reads the 15-entry register file, which writeback writes. All results are registered for the EXE stage; source-register numbers go combinationally to the hazard unit.

## Interface
Parameters:
- `REG_COUNT`, 15: general registers R0..R14; R15 is the PC.
- `WORD`, 32: datapath width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_in`  in  32  PC+4 from IF/ID.
- `instruction`  in  32  instruction from IF/ID.
- `status`  in  4  {N,Z,C,V} from the status register.
- `hazard`  in  1  hazard unit requests a bubble.
- `flush`  in  1  branch taken in EXE.
- `wb_en_in`, `wb_dest`, `wb_value`  in  1/4/32  writeback port.
- `src1`, `src2`, `two_src`  out  4/4/1  combinational, to the hazard unit.
- `pc`, `val_rn`, `val_rm`  out  32 each  registered.
- `exe_cmd`  out  4  registered.
- `mem_r_en`, `mem_w_en`, `wb_en`, `b`, `s`, `imm`  out  1 each  registered.
- `shift_operand`  out  12  registered.
- `signed_imm_24`  out  24  registered.
- `dest`  out  4  registered.

## Operation
- Mode field `instruction[27:26]`: 00 data-processing, 01 memory, 10 branch. 11 is decoded as a NOP with all controls 0.
- DP opcode `[24:21]` maps to `exe_cmd` as follows:
  - MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011.
  - SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111.
  - EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
  - Any other opcode is a NOP.
- DP control: `wb_en`=1 except CMP/TST; `s`=`instruction[20]`.
- Memory: `exe_cmd`=0010. `[20]`=1 is LDR (`mem_r_en`, `wb_en`); `[20]`=0 is STR (`mem_w_en`).
- Branch: `b`=1, no other control set.
- Field outputs:
  - `imm`=`[25]`, `shift_operand`=`[11:0]`, `signed_imm_24`=`[23:0]`, `dest`=`[15:12]`.
- Source registers:
  - `src1`=`[19:16]`.
  - `src2`=`[15:12]` for STR, else `[3:0]`.
  - `two_src`=~`[25]` | `mem_w_en`. MOV/MVN/B still report the values but are treated as don't-care by the hazard unit.
- Condition check on `[31:28]` against NZCV, full ARM table (EQ..AL); 1111 counts as fail.
- Condition fail or `hazard`=1: `exe_cmd`, `mem_r_en`, `mem_w_en`, `wb_en`, `b`, `s` are registered as 0. Data fields still register.
- Register file:
  - Written on rising `clk` when `wb_en_in`=1 and `wb_dest`≠15. A write to R15 is ignored.
  - Reads are combinational.
  - Read index 15 returns `pc_in`.
  - A same-cycle read of the register being written returns `wb_value` (bypass).

## Timing
- Latency: one cycle from `instruction` to registered outputs.
- Reset (`rst`=0, async): R0..R14 := 0; all registered outputs := 0. Reset mid-operation discards in-flight state immediately.
- `flush`=1 at an edge loads the same all-zero bubble as reset; the register file is still written.
- `flush` has priority over `hazard`; both only affect the ID/EX register and control fields.
- `hazard` does not stall this block. The IF/ID register is frozen externally, so the same instruction re-presents next cycle.
- `src1`/`src2`/`two_src` are combinational from `instruction` and valid whenever it is.

## Structure
- Shared package `arm_defs`: mode encodings, opcode constants, `exe_cmd` constants, condition codes.
- Sub-modules:
  - `register_file`: sequential, async active-low reset, with bypass.
  - `control_unit` and `condition_check`: combinational.
  - The stage register stays in `id_stage`.

## Test plan
- Reset release with `instruction`=E0000000 → every registered output 0, `exe_cmd`=0110 only after the next edge.
- WB writes R2=0x55 while `instruction`=E0821003 (ADD R1,R2,R3) → `val_rn`=0x55 the same edge (bypass); `exe_cmd`=0010, `wb_en`=1, `dest`=1.
- `status`=0100 (Z=1) with 10821003 (ADDNE) → all controls 0. With Z=0 → `wb_en`=1.
- E5810000 (STR R0,[R1]) → `src2`=0, `two_src`=1, `mem_w_en`=1, `wb_en`=0. E5910000 (LDR) → `mem_r_en`=1, `wb_en`=1.
- `hazard`=1 with E1A01002 (MOV) → bubble. With `flush`=1 as well → all-zero outputs. `rst` pulsed low mid-stream → R0..R14 read 0 afterwards.
- EAFFFFFE (B -2) → `b`=1, `signed_imm_24`=FFFFFE. Write to R15 → `val_rn` for Rn=15 still equals `pc_in`.
